// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one external asynchronous 32-bit SRAM between two requesters
//   (port 1 = instruction bus, port 2 = data bus). Contested requests are
//   granted alternately. The rd/wr strobes are held for WAIT_CYCLES+1
//   cycles. A DONE cycle follows that holds address, data and byte lanes.
//   Every output is registered.
// Ports
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_rd1/i_wr1/i_address1/i_wrdata1/   port 1 request (level, held until
//     i_dataenable1                     o_done1); rd+wr together = write
//   o_rddata1, o_done1                  port 1 read data, completion pulse
//   (same set with suffix 2 for port 2)
//   o_ram_address, o_ram_data_o,        SRAM address, write data,
//     i_ram_data_i, o_ram_data_oe       read data, bus drive enable
//   o_ram_rd_n, o_ram_wr_n              SRAM strobes, active-low
//   o_ram_dataenable                    SRAM byte lanes, active-high
module sram_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd1,
  input  logic              i_wr1,
  input  logic [ADDR_W-1:0] i_address1,
  input  logic [31:0]       i_wrdata1,
  input  logic [3:0]        i_dataenable1,
  output logic [31:0]       o_rddata1,
  output logic              o_done1,
  input  logic              i_rd2,
  input  logic              i_wr2,
  input  logic [ADDR_W-1:0] i_address2,
  input  logic [31:0]       i_wrdata2,
  input  logic [3:0]        i_dataenable2,
  output logic [31:0]       o_rddata2,
  output logic              o_done2,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic [31:0]       o_ram_data_o,
  input  logic [31:0]       i_ram_data_i,
  output logic              o_ram_data_oe,
  output logic              o_ram_rd_n,
  output logic              o_ram_wr_n,
  output logic [3:0]        o_ram_dataenable
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0] r_state;
  logic       r_last2;   // 1: last grant went to port 2
  logic       r_grant2;  // 1: current access belongs to port 2
  logic       r_is_wr;
  logic [3:0] r_cnt;

  logic              w_req1;
  logic              w_req2;
  logic              w_sel2;
  logic              w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [31:0]       w_sel_data;
  logic [3:0]        w_sel_be;

  always_comb begin
    w_req1     = i_rd1 | i_wr1;
    w_req2     = i_rd2 | i_wr2;
    // Under contention the port that did not win last time is chosen.
    w_sel2     = (w_req1 & w_req2) ? ~r_last2 : w_req2;
    w_sel_wr   = w_sel2 ? i_wr2 : i_wr1;
    w_sel_addr = w_sel2 ? i_address2 : i_address1;
    w_sel_data = w_sel2 ? i_wrdata2 : i_wrdata1;
    w_sel_be   = w_sel2 ? i_dataenable2 : i_dataenable1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= S_IDLE;
      r_last2          <= 1'b0;
      r_grant2         <= 1'b0;
      r_is_wr          <= 1'b0;
      r_cnt            <= '0;
      o_rddata1        <= '0;
      o_rddata2        <= '0;
      o_done1          <= 1'b0;
      o_done2          <= 1'b0;
      o_ram_address    <= '0;
      o_ram_data_o     <= '0;
      o_ram_data_oe    <= 1'b0;
      o_ram_rd_n       <= 1'b1;
      o_ram_wr_n       <= 1'b1;
      o_ram_dataenable <= '0;
    end else begin
      o_done1 <= 1'b0;
      o_done2 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          o_ram_data_oe <= 1'b0;
          if (w_req1 | w_req2) begin
            r_grant2         <= w_sel2;
            r_last2          <= w_sel2;
            r_is_wr          <= w_sel_wr;
            o_ram_address    <= w_sel_addr;
            o_ram_data_o     <= w_sel_data;
            o_ram_dataenable <= w_sel_be;
            // Strobe registers are set here so they are low for the whole
            // first ACCESS cycle.
            o_ram_rd_n       <= w_sel_wr;
            o_ram_wr_n       <= ~w_sel_wr;
            o_ram_data_oe    <= w_sel_wr;
            r_cnt            <= 4'(WAIT_CYCLES);
            r_state          <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state    <= S_DONE;
            o_ram_rd_n <= 1'b1;
            o_ram_wr_n <= 1'b1;
            if (r_grant2) begin
              o_done2 <= 1'b1;
              if (!r_is_wr) o_rddata2 <= i_ram_data_i;
            end else begin
              o_done1 <= 1'b1;
              if (!r_is_wr) o_rddata1 <= i_ram_data_i;
            end
          end
        end
        S_DONE: begin
          // Write data was driven through DONE for hold time; release now.
          o_ram_data_oe <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: begin
          o_ram_rd_n    <= 1'b1;
          o_ram_wr_n    <= 1'b1;
          o_ram_data_oe <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Self-checking bench for sram_arbiter. A behavioural SRAM sits on the
//   main instance's pins. A reference memory holds what each word should
//   contain according to the transactions issued. Two extra instances with
//   WAIT_CYCLES=0 and 15 cover the latency extremes.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rd1, wr1, rd2, wr2;
  logic [19:0] a1, a2;
  logic [31:0] wd1, wd2;
  logic [3:0]  be1, be2;
  logic [31:0] rdd1, rdd2;
  logic        dn1, dn2;
  logic [19:0] ram_a;
  logic [31:0] ram_do, ram_di;
  logic        oe, rdn, wrn;
  logic [3:0]  ram_be;

  sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd1(rd1), .i_wr1(wr1), .i_address1(a1), .i_wrdata1(wd1),
    .i_dataenable1(be1), .o_rddata1(rdd1), .o_done1(dn1),
    .i_rd2(rd2), .i_wr2(wr2), .i_address2(a2), .i_wrdata2(wd2),
    .i_dataenable2(be2), .o_rddata2(rdd2), .o_done2(dn2),
    .o_ram_address(ram_a), .o_ram_data_o(ram_do), .i_ram_data_i(ram_di),
    .o_ram_data_oe(oe), .o_ram_rd_n(rdn), .o_ram_wr_n(wrn),
    .o_ram_dataenable(ram_be)
  );

  // Latency-extreme instances: port 1 reads only; the SRAM returns a tag
  // derived from the address.
  logic        xrd0, xrd15;
  logic [19:0] xaddr;
  logic [31:0] x0_rdd1, x0_rdd2, x0_do, x0_di, x15_rdd1, x15_rdd2, x15_do, x15_di;
  logic        x0_dn1, x0_dn2, x0_oe, x0_rdn, x0_wrn;
  logic        x15_dn1, x15_dn2, x15_oe, x15_rdn, x15_wrn;
  logic [19:0] x0_ra, x15_ra;
  logic [3:0]  x0_be, x15_be;

  assign x0_di  = x0_rdn  ? 32'h0 : {12'hC00, x0_ra};
  assign x15_di = x15_rdn ? 32'h0 : {12'hC00, x15_ra};

  sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(0)) dut_w0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd1(xrd0), .i_wr1(1'b0), .i_address1(xaddr), .i_wrdata1(32'h0),
    .i_dataenable1(4'hF), .o_rddata1(x0_rdd1), .o_done1(x0_dn1),
    .i_rd2(1'b0), .i_wr2(1'b0), .i_address2(20'h0), .i_wrdata2(32'h0),
    .i_dataenable2(4'h0), .o_rddata2(x0_rdd2), .o_done2(x0_dn2),
    .o_ram_address(x0_ra), .o_ram_data_o(x0_do), .i_ram_data_i(x0_di),
    .o_ram_data_oe(x0_oe), .o_ram_rd_n(x0_rdn), .o_ram_wr_n(x0_wrn),
    .o_ram_dataenable(x0_be)
  );

  sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(15)) dut_w15 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd1(xrd15), .i_wr1(1'b0), .i_address1(xaddr), .i_wrdata1(32'h0),
    .i_dataenable1(4'hF), .o_rddata1(x15_rdd1), .o_done1(x15_dn1),
    .i_rd2(1'b0), .i_wr2(1'b0), .i_address2(20'h0), .i_wrdata2(32'h0),
    .i_dataenable2(4'h0), .o_rddata2(x15_rdd2), .o_done2(x15_dn2),
    .o_ram_address(x15_ra), .o_ram_data_o(x15_do), .i_ram_data_i(x15_di),
    .o_ram_data_oe(x15_oe), .o_ram_rd_n(x15_rdn), .o_ram_wr_n(x15_wrn),
    .o_ram_dataenable(x15_be)
  );

  // ---------------- behavioural SRAM and reference memory ----------------
  function automatic logic [31:0] init_val(input logic [11:0] a);
    return {4'hA, a, 4'h5, a};
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  logic [31:0]   sram_mem [0:4095];
  logic [4095:0] seen;
  logic          mem_clr = 1'b1;
  logic          pl_en = 1'b0;
  logic [11:0]   pl_a = '0;
  logic [31:0]   pl_d = '0;
  logic [31:0]   ref_mem [0:4095];

  function automatic logic [31:0] sram_peek(input logic [11:0] a);
    return seen[a] ? sram_mem[a] : init_val(a);
  endfunction

  always_comb begin
    ram_di = 32'h0;
    if (!rdn)
      ram_di = seen[ram_a[11:0]] ? sram_mem[ram_a[11:0]] : init_val(ram_a[11:0]);
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      seen <= '0;
    end else begin
      if (pl_en) begin
        sram_mem[pl_a] <= pl_d;
        seen[pl_a]     <= 1'b1;
      end
      if (!wrn && oe) begin
        sram_mem[ram_a[11:0]] <= merge_word(sram_peek(ram_a[11:0]), ram_do, ram_be);
        seen[ram_a[11:0]]     <= 1'b1;
      end
    end
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rd1 = 0; wr1 = 0; rd2 = 0; wr2 = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One access on one port, started in an IDLE cycle (posedge+1). Returns
  // observations; callers compare them against expectations.
  task automatic xfer(input bit p2, input bit wr, input logic [19:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      output int lat, output int rdlo, output int wrlo,
                      output int oehi, output int bad, output bit odone,
                      output logic [31:0] rd, output logic oe_after);
    int cyc;
    bit rdbit;
    lat = -1; rdlo = 0; wrlo = 0; oehi = 0; bad = 0; odone = 0; rd = '0; cyc = 0;
    rdbit = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    if (p2) begin rd2 = rdbit; wr2 = wr; a2 = a; wd2 = d; be2 = be; end
    else    begin rd1 = rdbit; wr1 = wr; a1 = a; wd1 = d; be1 = be; end
    while (lat < 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (!rdn) rdlo++;
      if (!wrn) wrlo++;
      if (oe) oehi++;
      if (!rdn && !wrn) bad++;
      if (ram_a !== a || ram_be !== be || (wr && ram_do !== d)) bad++;
      if (p2 ? dn1 : dn2) odone = 1;
      if (p2 ? dn2 : dn1) begin
        lat = cyc;
        rd  = p2 ? rdd2 : rdd1;
      end
    end
    rd1 = 0; wr1 = 0; rd2 = 0; wr2 = 0;
    if (wr) ref_mem[a[11:0]] = merge_word(ref_mem[a[11:0]], d, be);
    @(posedge clk); #1;
    oe_after = oe;
  endtask

  // ------------------------------- tests ---------------------------------
  task automatic test_reset();
    rst_n = 1'b0; mem_clr = 1'b1;
    rd1 = 0; wr1 = 0; rd2 = 0; wr2 = 0; a1 = '0; a2 = '0;
    wd1 = '0; wd2 = '0; be1 = '0; be2 = '0; xrd0 = 0; xrd15 = 0; xaddr = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdn !== 1'b1) begin errors++; $display("FAIL reset_rd_n got %b exp 1", rdn); end
    checks++; if (wrn !== 1'b1) begin errors++; $display("FAIL reset_wr_n got %b exp 1", wrn); end
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", oe); end
    checks++; if (ram_a !== 20'h0 || ram_do !== 32'h0 || ram_be !== 4'h0) begin
      errors++; $display("FAIL reset_bus got a=%h d=%h be=%h exp 0", ram_a, ram_do, ram_be); end
    checks++; if (rdd1 !== 32'h0 || rdd2 !== 32'h0) begin
      errors++; $display("FAIL reset_rddata got %h/%h exp 0", rdd1, rdd2); end
    checks++; if (dn1 !== 1'b0 || dn2 !== 1'b0) begin
      errors++; $display("FAIL reset_done got %b/%b exp 0", dn1, dn2); end
    mem_clr = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    int lat, rdlo, wrlo, oehi, bad; bit od; logic [31:0] rd; logic oa;
    preload(12'h123, 32'hDEADBEEF);
    xfer(1'b0, 1'b0, 20'h00123, 32'h0, 4'hF, lat, rdlo, wrlo, oehi, bad, od, rd, oa);
    checks++; if (lat != 3) begin errors++; $display("FAIL read_latency got %0d exp 3", lat); end
    checks++; if (rdlo != 2 || wrlo != 0) begin
      errors++; $display("FAIL read_strobes got rd_low=%0d wr_low=%0d exp 2/0", rdlo, wrlo); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data got %h exp deadbeef", rd); end
    checks++; if (od || oehi != 0) begin
      errors++; $display("FAIL read_side got other_done=%0d oe_cycles=%0d exp 0/0", od, oehi); end
    checks++; if (bad != 0) begin errors++; $display("FAIL read_bus_stable got %0d bad cycles exp 0", bad); end
    checks++; if (rdd2 !== 32'h0) begin errors++; $display("FAIL read_rddata2 got %h exp 0", rdd2); end
  endtask

  task automatic test_write();
    int lat, rdlo, wrlo, oehi, bad; bit od; logic [31:0] rd, w, prev2; logic oa;
    prev2 = rdd2;
    xfer(1'b1, 1'b1, 20'h00040, 32'h12345678, 4'b0011, lat, rdlo, wrlo, oehi, bad, od, rd, oa);
    w = sram_peek(12'h040);
    checks++; if (lat != 3) begin errors++; $display("FAIL write_latency got %0d exp 3", lat); end
    checks++; if (wrlo != 2 || rdlo != 0) begin
      errors++; $display("FAIL write_strobes got wr_low=%0d rd_low=%0d exp 2/0", wrlo, rdlo); end
    checks++; if (oehi != 3 || oa !== 1'b0) begin
      errors++; $display("FAIL write_oe got cycles=%0d after=%b exp 3/0", oehi, oa); end
    checks++; if (bad != 0) begin errors++; $display("FAIL write_bus_stable got %0d bad cycles exp 0", bad); end
    checks++; if (w !== ref_mem[12'h040] || w[15:0] !== 16'h5678) begin
      errors++; $display("FAIL write_mem got %h exp %h", w, ref_mem[12'h040]); end
    checks++; if (rdd2 !== prev2 || od) begin
      errors++; $display("FAIL write_side got rddata2=%h other_done=%0d exp %h/0", rdd2, od, prev2); end
  endtask

  task automatic test_simultaneous();
    int c1, c2, cyc;
    logic [31:0] v1, v2;
    c1 = -1; c2 = -1; cyc = 0; v1 = '0; v2 = '0;
    do_reset();
    a1 = 20'h00010; a2 = 20'h00020; be1 = 4'hF; be2 = 4'hF;
    rd1 = 1; rd2 = 1;
    while ((c1 < 0 || c2 < 0) && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (dn2) begin c2 = cyc; v2 = rdd2; rd2 = 0; end
      if (dn1) begin c1 = cyc; v1 = rdd1; rd1 = 0; end
    end
    rd1 = 0; rd2 = 0;
    @(posedge clk); #1;
    checks++; if (c2 != 3) begin errors++; $display("FAIL simul_done2_cycle got %0d exp 3", c2); end
    checks++; if (c1 != 7) begin errors++; $display("FAIL simul_done1_cycle got %0d exp 7", c1); end
    checks++; if (v1 !== ref_mem[12'h010] || v2 !== ref_mem[12'h020]) begin
      errors++; $display("FAIL simul_data got %h/%h exp %h/%h", v1, v2, ref_mem[12'h010], ref_mem[12'h020]); end
  endtask

  task automatic test_contention();
    int got, cyc, p, exp_p, m_last;
    bit pend1, pend2;
    logic [31:0] prev1, prev2;
    do_reset();
    m_last = 1;   // reset state: last grant = port 1
    got = 0; cyc = 0; pend1 = 0; pend2 = 0;
    prev1 = rdd1; prev2 = rdd2;
    a1 = 20'($urandom_range(0, 63)); a2 = 20'($urandom_range(64, 127));
    rd1 = 1; rd2 = 1;
    while (got < 6 && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (pend1) begin a1 = 20'($urandom_range(0, 63)); rd1 = 1; pend1 = 0; end
      if (pend2) begin a2 = 20'($urandom_range(64, 127)); rd2 = 1; pend2 = 0; end
      if (dn1 && dn2) begin
        checks++; errors++; $display("FAIL contention_both_done got 1/1 exp one");
      end else if (dn1 || dn2) begin
        p = dn2 ? 2 : 1;
        exp_p = (m_last == 1) ? 2 : 1;
        checks++; if (p != exp_p) begin
          errors++; $display("FAIL contention_order access %0d got port %0d exp %0d", got, p, exp_p); end
        m_last = p;
        if (p == 1) begin
          checks++; if (rdd1 !== ref_mem[a1[11:0]] || rdd2 !== prev2) begin
            errors++; $display("FAIL contention_data1 got %h/%h exp %h/%h", rdd1, rdd2, ref_mem[a1[11:0]], prev2); end
          prev1 = rdd1; rd1 = 0; pend1 = 1;
        end else begin
          checks++; if (rdd2 !== ref_mem[a2[11:0]] || rdd1 !== prev1) begin
            errors++; $display("FAIL contention_data2 got %h/%h exp %h/%h", rdd2, rdd1, ref_mem[a2[11:0]], prev1); end
          prev2 = rdd2; rd2 = 0; pend2 = 1;
        end
        got++;
      end
    end
    rd1 = 0; rd2 = 0;
    @(posedge clk); #1;
    checks++; if (got != 6) begin errors++; $display("FAIL contention_count got %0d exp 6", got); end
  endtask

  task automatic test_reset_mid();
    int lat, cyc; bit sdone;
    logic [31:0] d;
    d = $urandom;
    lat = -1; cyc = 0; sdone = 0;
    rd2 = 0; wr2 = 1; a2 = 20'h00055; wd2 = d; be2 = 4'hF;
    @(posedge clk); #1;
    checks++; if (wrn !== 1'b0 || oe !== 1'b1) begin
      errors++; $display("FAIL midreset_pre got wr_n=%b oe=%b exp 0/1", wrn, oe); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wrn !== 1'b1 || oe !== 1'b0 || rdn !== 1'b1) begin
      errors++; $display("FAIL midreset_async got wr_n=%b oe=%b rd_n=%b exp 1/0/1", wrn, oe, rdn); end
    repeat (3) begin
      @(posedge clk); #1;
      if (dn1 || dn2) sdone = 1;
    end
    checks++; if (sdone) begin errors++; $display("FAIL midreset_no_done got 1 exp 0"); end
    rst_n = 1'b1;
    while (lat < 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (dn2) lat = cyc;
    end
    wr2 = 0;
    ref_mem[12'h055] = d;
    @(posedge clk); #1;
    checks++; if (lat != 3) begin errors++; $display("FAIL midreset_retry_latency got %0d exp 3", lat); end
    checks++; if (sram_peek(12'h055) !== d) begin
      errors++; $display("FAIL midreset_retry_mem got %h exp %h", sram_peek(12'h055), d); end
  endtask

  task automatic test_random();
    int lat, rdlo, wrlo, oehi, bad; bit od; logic [31:0] rd, d, p1, p2v; logic oa;
    bit port2, wr; logic [19:0] a; logic [3:0] be;
    for (int n = 0; n < 24; n++) begin
      port2 = 1'($urandom_range(0, 1));
      wr    = 1'($urandom_range(0, 1));
      a     = 20'($urandom_range(0, 63));
      d     = $urandom;
      be    = (n == 5) ? 4'h0 : 4'($urandom_range(0, 15));
      p1 = rdd1; p2v = rdd2;
      xfer(port2, wr, a, d, be, lat, rdlo, wrlo, oehi, bad, od, rd, oa);
      checks++; if (lat != 3 || bad != 0 || od || oa !== 1'b0) begin
        errors++; $display("FAIL rand_access %0d got lat=%0d bad=%0d od=%0d oe_after=%b exp 3/0/0/0", n, lat, bad, od, oa); end
      checks++; if ((wr ? wrlo : rdlo) != 2 || (wr ? rdlo : wrlo) != 0 || oehi != (wr ? 3 : 0)) begin
        errors++; $display("FAIL rand_strobes %0d got rd=%0d wr=%0d oe=%0d", n, rdlo, wrlo, oehi); end
      if (wr) begin
        checks++; if (sram_peek(a[11:0]) !== ref_mem[a[11:0]] || rdd1 !== p1 || rdd2 !== p2v) begin
          errors++; $display("FAIL rand_write %0d got %h exp %h", n, sram_peek(a[11:0]), ref_mem[a[11:0]]); end
      end else begin
        checks++; if (rd !== ref_mem[a[11:0]] || (port2 ? rdd1 !== p1 : rdd2 !== p2v)) begin
          errors++; $display("FAIL rand_read %0d got %h exp %h", n, rd, ref_mem[a[11:0]]); end
      end
    end
  endtask

  task automatic test_wait_extremes();
    int c0, c15, cyc, lo15;
    c0 = -1; c15 = -1; cyc = 0; lo15 = 0;
    xaddr = 20'h00ABC;
    xrd0 = 1; xrd15 = 1;
    while ((c0 < 0 || c15 < 0) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (!x15_rdn) lo15++;
      if (x0_dn1)  begin c0 = cyc;  xrd0 = 0; end
      if (x15_dn1) begin c15 = cyc; xrd15 = 0; end
    end
    xrd0 = 0; xrd15 = 0;
    checks++; if (c0 != 2) begin errors++; $display("FAIL wait0_done_cycle got %0d exp 2", c0); end
    checks++; if (c15 != 17) begin errors++; $display("FAIL wait15_done_cycle got %0d exp 17", c15); end
    checks++; if (lo15 != 16) begin errors++; $display("FAIL wait15_strobe_width got %0d exp 16", lo15); end
    checks++; if (x0_rdd1 !== 32'hC0000ABC || x15_rdd1 !== 32'hC0000ABC) begin
      errors++; $display("FAIL wait_extreme_data got %h/%h exp c0000abc", x0_rdd1, x15_rdd1); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    test_reset();
    test_read();
    test_write();
    test_simultaneous();
    test_contention();
    test_reset_mid();
    test_random();
    test_wait_extremes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Single-clock arbiter and sequencer that shares one external asynchronous 32-bit SRAM between the instruction-bus requester (port 1) and the data-bus requester (port 2). It sits between the ibus/dbus RAM slave interfaces and the SRAM pins. It serialises the two requesters with alternating priority and generates the SRAM strobe timing with a programmable number of wait cycles. It is the single-clock replacement for the clk2x time-multiplexed RAM path.

## Interface
- ADDR_W, 20, SRAM word-address width.
- WAIT_CYCLES, 1, extra cycles the rd/wr strobe is held beyond the first (strobe width = WAIT_CYCLES+1 cycles); legal range 0..15.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rd1 / wr1  in  1 each  port 1 read/write request, level, held until done1.
- address1  in  ADDR_W  port 1 word address.
- wrdata1  in  32  port 1 write data.
- dataenable1  in  4  port 1 byte enables, active-high.
- rddata1  out  32  port 1 read data.
- done1  out  1  port 1 completion pulse.
- rd2, wr2, address2, wrdata2, dataenable2, rddata2, done2: identical set for port 2.
- ram_address  out  ADDR_W  SRAM address.
- ram_data_o  out  32  SRAM write data.
- ram_data_i  in  32  SRAM read data.
- ram_data_oe  out  1  tri-state enable; the top level drives the inout bus when this is high.
- ram_rd_n / ram_wr_n  out  1 each  SRAM output/write strobes, active-low.
- ram_dataenable  out  4  byte lanes, active-high.

## Operation
- All outputs are registered.
- Reset values:
  - ram_rd_n=1, ram_wr_n=1, ram_data_oe=0.
  - ram_address=0, ram_data_o=0, ram_dataenable=0.
  - rddata1=rddata2=0, done1=done2=0.
  - state=IDLE, last_grant=port 1.
- A port requests when rd or wr is high. If rd and wr are both high, the access is a write.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - With no request, stay in IDLE.
  - With exactly one port requesting, grant it.
  - With both requesting, grant the port that is not last_grant. The first contest after reset therefore goes to port 2.
  - On a grant, latch address, data, byte enables, op and grant into the SRAM output registers; set last_grant; load wait counter = WAIT_CYCLES; go to ACCESS.
- ACCESS:
  - The selected strobe (ram_rd_n or ram_wr_n) is low. For a write, ram_data_oe=1.
  - If the counter is nonzero, decrement it and stay in ACCESS.
  - If the counter is zero, go to DONE. On a read, capture ram_data_i into the granted port's rddata register on this edge.
- DONE:
  - Both strobes are high.
  - Address, ram_data_o and ram_dataenable are held. For a write, ram_data_oe stays 1 to provide data hold time.
  - The granted port's done is 1 for exactly this cycle.
  - Next state is IDLE. ram_data_oe clears on entry to IDLE.
- rddataN holds its last captured value until the next read on that port. Writes do not change rddata.
- A zero dataenable still runs a full access with ram_dataenable=0.
- Request inputs are sampled only in IDLE. Changing a request during ACCESS/DONE has no effect.
- The requester must deassert rd/wr in the cycle after done. A request still high in IDLE starts a new access.
- Reset mid-access: strobes go high and ram_data_oe goes low asynchronously. No done is issued. FSM returns to IDLE.

## Timing
- The request is seen in cycle 0 (IDLE).
- ACCESS occupies cycles 1..WAIT_CYCLES+1.
- done and valid rddata appear in cycle WAIT_CYCLES+2.
- The earliest next grant is in cycle WAIT_CYCLES+3.
- Per-access occupancy is WAIT_CYCLES+3 cycles.
- With both ports continuously requesting, grants strictly alternate. Each port waits at most one foreign access.
- Address, data and byte enables are stable from the first ACCESS cycle through DONE. Strobes never toggle while the address changes.
- ram_rd_n and ram_wr_n are never low in the same cycle.

## Test plan
- Read, WAIT_CYCLES=1: port 1 rd, address1=0x00123, SRAM model returns 0xDEADBEEF → ram_rd_n low in cycles 1–2, done1=1 in cycle 3, rddata1=0xDEADBEEF, done2 stays 0.
- Write: port 2 wr, address2=0x00040, wrdata2=0x12345678, dataenable2=4'b0011 → ram_wr_n low 2 cycles, ram_data_oe high cycles 1–3, ram_dataenable=0011, model word 0x40 low half = 0x5678.
- Simultaneous after reset: rd1 and rd2 rise together → port 2 served first (done2 cycle 3), then port 1 (done1 cycle 7).
- Continuous contention: both ports hold requests (re-raised after done) for 6 accesses → grant order 2,1,2,1,2,1, and no rddata cross-contamination between ports.
- Reset mid-access: assert rst_n=0 in the first ACCESS cycle of a write → ram_wr_n=1 and ram_data_oe=0 immediately, no done; after release, the first transaction completes normally.
- WAIT_CYCLES=0 and 15: single read → done at cycle 2 and cycle 17 respectively.
